// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: byte-wide UART transmitter.
// Accepts a one-cycle TX_start pulse in IDLE and sends TX_data LSB-first as a
// start bit, DATA_BITS data bits, an optional parity bit and STOP_BITS stop bits.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous reset, active-low
//   TX_start  send request, only honoured in IDLE
//   TX_data   payload, captured on the accepting edge
//   TX_busy   high for the whole frame (registered)
//   TX_done   one-cycle pulse on the cycle TX_busy falls (registered)
//   tx_line   serial output, idles high (registered)
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 TX_start,
    input  logic [DATA_BITS-1:0] TX_data,
    output logic                 TX_busy,
    output logic                 TX_done,
    output logic                 tx_line
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q,  baud_d;
    logic [BIT_W-1:0]     bit_q,   bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q,   par_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 line_q,  line_d;
    logic                 baud_tick;

    assign TX_busy = busy_q;
    assign TX_done = done_q;
    assign tx_line = line_q;

    // Last cycle of the current bit period.
    assign baud_tick = (baud_q == BAUD_LAST);

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        line_d  = line_q;

        if (state_q != IDLE) begin
            baud_d = baud_tick ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                line_d = 1'b1;
                if (TX_start) begin
                    state_d = START;
                    shreg_d = TX_data;
                    // Parity is fixed at capture so later TX_data changes cannot leak in.
                    par_d   = (^TX_data) ^ 1'(PARITY_ODD);
                    busy_d  = 1'b1;
                    line_d  = 1'b0;
                end
            end

            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                    line_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end

            DATA: begin
                if (baud_tick) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            line_d  = par_q;
                        end else begin
                            state_d = STOP;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        line_d  = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                    end
                end
            end

            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    bit_d   = '0;
                    line_d  = 1'b1;
                end
            end

            STOP: begin
                line_d = 1'b1;
                if (baud_tick) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = '0;
                busy_d  = 1'b0;
                line_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            line_q  <= line_d;
        end
    end

endmodule
